// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, instruction field positions and widths shared
// by the fetch/sequencing stage and its PC sub-module.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int CNT_W   = 4;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter register with synchronous reset, increment
// and a direct load used for taken branches.
module pc_counter
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  // Load wins over increment; the increment wraps silently at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instruction words over a req/ack handshake,
// holds them in the IR, splits out the fields and raises HAB once per
// instruction during the execute phase. Define FETCH_BRANCH_EN to add the
// BR_TAKEN/BR_TARGET branch inputs; without it the PC always increments.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                EXEC_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  output logic                IMEM_REQ,
  output logic [ADDR_W-1:0]   IMEM_ADDR,
  input  logic                IMEM_ACK,
  input  logic [INSTR_W-1:0]  IMEM_DATA,
  input  logic                STALL,
`ifdef FETCH_BRANCH_EN
  input  logic                BR_TAKEN,
  input  logic [ADDR_W-1:0]   BR_TARGET,
`endif
  output logic [OP_W-1:0]     OP_CODE,
  output logic [FUNCT_W-1:0]  FUNCT,
  output logic [REG_W-1:0]    RS,
  output logic [REG_W-1:0]    RT,
  output logic [REG_W-1:0]    RD,
  output logic [IMM_W-1:0]    IMM,
  output logic                HAB,
  output logic [ADDR_W-1:0]   PC,
  output logic                HALTED
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXEC_CYCLES - 1);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [CNT_W-1:0]   exec_cnt;
  logic [ADDR_W-1:0]  pc;
  logic               exec_last;
  logic               br_take;
  logic [ADDR_W-1:0]  br_target;

`ifdef FETCH_BRANCH_EN
  assign br_take   = BR_TAKEN;
  assign br_target = BR_TARGET;
`else
  assign br_take   = 1'b0;
  assign br_target = '0;
`endif

  assign exec_last = (state == EXEC) && !STALL && (exec_cnt == LAST_CNT);

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (CLK),
    .reset      (RESET),
    .inc        (exec_last && !br_take),
    .load       (exec_last && br_take),
    .load_value (br_target),
    .pc         (pc)
  );

  // Sequencer: IDLE -> FETCH -> DECODE -> EXEC (or HALT), with the IR
  // captured on ACK and the exec counter frozen while STALL is high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      ir       <= '0;
      exec_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (RUN) state <= FETCH;
        end
        FETCH: begin
          if (IMEM_ACK) begin
            ir    <= IMEM_DATA;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= (ir == HALT_WORD) ? HALT : EXEC;
        end
        EXEC: begin
          if (!STALL) begin
            if (exec_cnt == LAST_CNT) begin
              exec_cnt <= '0;
              state    <= RUN ? FETCH : IDLE;
            end else begin
              exec_cnt <= exec_cnt + CNT_W'(1);
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign IMEM_REQ  = (state == FETCH);
  assign HAB       = (state == EXEC);
  assign HALTED    = (state == HALT);
  assign IMEM_ADDR = pc;
  assign PC        = pc;

  assign OP_CODE = ir[OP_MSB:OP_LSB];
  assign FUNCT   = ir[FUNCT_MSB:FUNCT_LSB];
  assign RS      = ir[RS_MSB:RS_LSB];
  assign RT      = ir[RT_MSB:RT_LSB];
  assign RD      = ir[RD_MSB:RD_LSB];
  assign IMM     = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer. Instance A
// (ADDR_W=8, EXEC_CYCLES=1) is tracked every cycle by an instruction-level
// model; instance B (ADDR_W=4, RESET_PC=15, EXEC_CYCLES=2) covers PC wrap
// and stalls with hand-computed expectations.
module tb_fetch_sequencer;

  localparam int A_EXEC = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        a_reset, a_run, a_ack, a_stall;
  logic [31:0] a_data;
  logic        a_req, a_hab, a_halted;
  logic [7:0]  a_addr, a_pc;
  logic [5:0]  a_op, a_funct;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [15:0] a_imm;
`ifdef FETCH_BRANCH_EN
  logic        a_br_taken = 1'b0;
  logic [7:0]  a_br_target = 8'h00;
`endif

  logic        b_reset, b_run, b_ack, b_stall;
  logic [31:0] b_data;
  logic        b_req, b_hab, b_halted;
  logic [3:0]  b_addr, b_pc;
  logic [5:0]  b_op, b_funct;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Instruction-level model of instance A
  logic [7:0]  m_pc = 8'h00;
  logic [31:0] m_ir = 32'h0;
  bit          m_req = 1'b0, m_hab = 1'b0, m_halt = 1'b0, m_pending = 1'b0;
  int          m_left = 0;

  fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'd0), .EXEC_CYCLES(A_EXEC)) dut_a (
    .CLK(CLK), .RESET(a_reset), .RUN(a_run),
    .IMEM_REQ(a_req), .IMEM_ADDR(a_addr), .IMEM_ACK(a_ack), .IMEM_DATA(a_data),
    .STALL(a_stall),
`ifdef FETCH_BRANCH_EN
    .BR_TAKEN(a_br_taken), .BR_TARGET(a_br_target),
`endif
    .OP_CODE(a_op), .FUNCT(a_funct), .RS(a_rs), .RT(a_rt), .RD(a_rd), .IMM(a_imm),
    .HAB(a_hab), .PC(a_pc), .HALTED(a_halted)
  );

  fetch_sequencer #(.ADDR_W(4), .RESET_PC(4'd15), .EXEC_CYCLES(2)) dut_b (
    .CLK(CLK), .RESET(b_reset), .RUN(b_run),
    .IMEM_REQ(b_req), .IMEM_ADDR(b_addr), .IMEM_ACK(b_ack), .IMEM_DATA(b_data),
    .STALL(b_stall),
`ifdef FETCH_BRANCH_EN
    .BR_TAKEN(1'b0), .BR_TARGET(4'd0),
`endif
    .OP_CODE(b_op), .FUNCT(b_funct), .RS(b_rs), .RT(b_rt), .RD(b_rd), .IMM(b_imm),
    .HAB(b_hab), .PC(b_pc), .HALTED(b_halted)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs to the selected instance; the other is held in reset.
  task automatic applyStimulus(input bit sel, input bit rst, input bit run, input bit ack,
                               input logic [31:0] data, input bit stall);
    a_reset = sel ? 1'b1 : rst;
    a_run   = sel ? 1'b0 : run;
    a_ack   = sel ? 1'b0 : ack;
    a_data  = sel ? 32'h0 : data;
    a_stall = sel ? 1'b0 : stall;
    b_reset = sel ? rst : 1'b1;
    b_run   = sel ? run : 1'b0;
    b_ack   = sel ? ack : 1'b0;
    b_data  = sel ? data : 32'h0;
    b_stall = sel ? stall : 1'b0;
    @(negedge CLK);
  endtask

  // Resets instance A and retires n NOPs with a zero-wait memory.
  task automatic runNops(input int n);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      if (i == 0) checkOutput("nop_hab", 32'(a_hab), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
  endtask

  // Model: advances one instruction phase per handshake, counting down exec work.
  always @(posedge CLK) begin
    if (a_reset) begin
      m_pc = 8'h00; m_ir = 32'h0; m_req = 1'b0; m_hab = 1'b0;
      m_halt = 1'b0; m_pending = 1'b0; m_left = 0;
    end else if (m_halt) begin
      m_req = 1'b0;
    end else if (m_req) begin
      if (a_ack) begin
        m_ir = a_data; m_req = 1'b0; m_pending = 1'b1;
      end
    end else if (m_pending) begin
      m_pending = 1'b0;
      if (m_ir == 32'hFFFF_FFFF) m_halt = 1'b1;
      else begin m_hab = 1'b1; m_left = A_EXEC; end
    end else if (m_hab) begin
      if (!a_stall) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hab = 1'b0;
          m_pc = m_pc + 8'd1;
`ifdef FETCH_BRANCH_EN
          if (a_br_taken) m_pc = a_br_target;
`endif
          m_req = a_run;
        end
      end
    end else if (a_run) begin
      m_req = 1'b1;
    end
  end

  // Every-cycle comparison of instance A against the model
  always @(negedge CLK) begin
    if (check_en) begin
      checkOutput("a_req",    32'(a_req),    32'(m_req));
      checkOutput("a_hab",    32'(a_hab),    32'(m_hab));
      checkOutput("a_halted", 32'(a_halted), 32'(m_halt));
      checkOutput("a_pc",     32'(a_pc),     32'(m_pc));
      checkOutput("a_addr",   32'(a_addr),   32'(m_pc));
      checkOutput("a_op",     32'(a_op),     32'(m_ir[31:26]));
      checkOutput("a_rs",     32'(a_rs),     32'(m_ir[25:21]));
      checkOutput("a_rt",     32'(a_rt),     32'(m_ir[20:16]));
      checkOutput("a_rd",     32'(a_rd),     32'(m_ir[15:11]));
      checkOutput("a_funct",  32'(a_funct),  32'(m_ir[5:0]));
      checkOutput("a_imm",    32'(a_imm),    32'(m_ir[15:0]));
    end
  end

  initial begin
    int hab_count;
    int pc_changes;
    logic [3:0] prev_pc;
    logic [5:0] stall_pat;

    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_req", 32'(a_req), 32'd0);
    checkOutput("rst_hab", 32'(a_hab), 32'd0);
    checkOutput("rst_pc", 32'(a_pc), 32'd0);
    checkOutput("rst_halted", 32'(a_halted), 32'd0);
    checkOutput("rst_op", 32'(a_op), 32'd0);

    $display("[TB] zero-wait fetch of 00221820");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t1_req", 32'(a_req), 32'd1);
    checkOutput("t1_addr", 32'(a_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0022_1820, 1'b0);
    checkOutput("t1_op", 32'(a_op), 32'd0);
    checkOutput("t1_funct", 32'(a_funct), 32'h20);
    checkOutput("t1_rs", 32'(a_rs), 32'd1);
    checkOutput("t1_rt", 32'(a_rt), 32'd2);
    checkOutput("t1_rd", 32'(a_rd), 32'd3);
    checkOutput("t1_hab_decode", 32'(a_hab), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t1_hab_exec", 32'(a_hab), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t1_hab_after", 32'(a_hab), 32'd0);
    checkOutput("t1_req_next", 32'(a_req), 32'd1);
    checkOutput("t1_addr_next", 32'(a_addr), 32'd1);

    $display("[TB] delayed ack and reset during fetch");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("t2_wait_req", 32'(a_req), 32'd1);
      checkOutput("t2_wait_addr", 32'(a_addr), 32'd1);
      checkOutput("t2_wait_hab", 32'(a_hab), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h012A_4022, 1'b0);
    checkOutput("t2_rd", 32'(a_rd), 32'd8);
    checkOutput("t2_funct", 32'(a_funct), 32'h22);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t2_addr2", 32'(a_addr), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("t2_rst_req", 32'(a_req), 32'd0);
    checkOutput("t2_rst_pc", 32'(a_pc), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t2_late_op", 32'(a_op), 32'd0);
    checkOutput("t2_late_imm", 32'(a_imm), 32'd0);
    checkOutput("t2_late_req", 32'(a_req), 32'd0);

    $display("[TB] halt word");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("t5_halted_decode", 32'(a_halted), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_halted", 32'(a_halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i % 2) == 0, 32'h0, 1'b0);
      checkOutput("t5_hold_req", 32'(a_req), 32'd0);
      checkOutput("t5_hold_hab", 32'(a_hab), 32'd0);
      checkOutput("t5_hold_halted", 32'(a_halted), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_cleared", 32'(a_halted), 32'd0);

    $display("[TB] NOP run to PC=5");
    runNops(5);
    checkOutput("t6_pc5", 32'(a_pc), 32'd5);
`ifdef FETCH_BRANCH_EN
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    a_br_taken = 1'b1; a_br_target = 8'h40;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    a_br_taken = 1'b0; a_br_target = 8'h00;
    checkOutput("t6_taken_addr", 32'(a_addr), 32'h40);
    runNops(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    a_br_taken = 1'b1; a_br_target = 8'h40;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    a_br_taken = 1'b0; a_br_target = 8'h00;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_decode_only_addr", 32'(a_addr), 32'd6);
`else
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_inc_addr", 32'(a_addr), 32'd6);
`endif

    $display("[TB] instance B: PC wrap with ADDI");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("b_rst_pc", 32'(b_pc), 32'd15);
    checkOutput("b_rst_fields", {b_op, b_funct, b_rs, b_rt, b_rd, 5'd0}, 32'd0);
    checkOutput("b_rst_imm", 32'(b_imm), 32'd0);
    checkOutput("b_rst_halted", 32'(b_halted), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_req", 32'(b_req), 32'd1);
    checkOutput("t4_addr15", 32'(b_addr), 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h2001_0005, 1'b0);
    checkOutput("t4_op", 32'(b_op), 32'h08);
    checkOutput("t4_imm", 32'(b_imm), 32'h0005);
    checkOutput("t4_rt", 32'(b_rt), 32'd1);
    checkOutput("t4_hab_decode", 32'(b_hab), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_hab1", 32'(b_hab), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_hab2", 32'(b_hab), 32'd1);
    checkOutput("t4_pc_hold", 32'(b_pc), 32'd15);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_hab_end", 32'(b_hab), 32'd0);
    checkOutput("t4_wrap_addr", 32'(b_addr), 32'd0);

    $display("[TB] instance B: stall inside exec");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0043_2020, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    hab_count = int'(b_hab);
    pc_changes = 0;
    prev_pc = b_pc;
    stall_pat = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, stall_pat[i]);
      hab_count += int'(b_hab);
      if (b_pc != prev_pc) pc_changes++;
      prev_pc = b_pc;
    end
    checkOutput("t3_hab_cycles", 32'(hab_count), 32'd5);
    checkOutput("t3_pc_changes", 32'(pc_changes), 32'd1);
    checkOutput("t3_pc", 32'(b_pc), 32'd1);
    checkOutput("t3_req", 32'(b_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
